// File: rtl/seq_ctrl_pkg.sv
// seq_ctrl_pkg: shared encodings for the multi-cycle instruction sequencer.
//   OPCODE_*  : major opcodes the sequencer understands (instruction[6:0])
//   FUNCT_S*  : legal store funct3 values
//   STORE_*   : store width encoding driven on storeops
//   SEQ_ST_*  : 3-bit state encodings
//   TRAP_*    : trap cause codes
// decode_instr() classifies an opcode/funct3 pair and flags illegal encodings.
package seq_ctrl_pkg;

  localparam logic [6:0] OPCODE_R = 7'b0110011;
  localparam logic [6:0] OPCODE_I = 7'b0000011;  // loads
  localparam logic [6:0] OPCODE_S = 7'b0100011;
  localparam logic [6:0] OPCODE_B = 7'b1100011;

  localparam logic [2:0] FUNCT_SB = 3'b000;
  localparam logic [2:0] FUNCT_SH = 3'b001;
  localparam logic [2:0] FUNCT_SW = 3'b010;

  localparam logic [1:0] STORE_NONE = 2'd0;
  localparam logic [1:0] STORE_B    = 2'd1;
  localparam logic [1:0] STORE_H    = 2'd2;
  localparam logic [1:0] STORE_W    = 2'd3;

  localparam logic [2:0] SEQ_ST_IDLE   = 3'd0;
  localparam logic [2:0] SEQ_ST_FETCH  = 3'd1;
  localparam logic [2:0] SEQ_ST_DECODE = 3'd2;
  localparam logic [2:0] SEQ_ST_EXEC   = 3'd3;
  localparam logic [2:0] SEQ_ST_MEM    = 3'd4;
  localparam logic [2:0] SEQ_ST_WB     = 3'd5;
  localparam logic [2:0] SEQ_ST_TRAP   = 3'd6;

  localparam logic [1:0] TRAP_NONE    = 2'd0;
  localparam logic [1:0] TRAP_ILLEGAL = 2'd1;
  localparam logic [1:0] TRAP_IMEM_TO = 2'd2;
  localparam logic [1:0] TRAP_DMEM_TO = 2'd3;

  typedef enum logic [2:0] {
    StIdle   = SEQ_ST_IDLE,
    StFetch  = SEQ_ST_FETCH,
    StDecode = SEQ_ST_DECODE,
    StExec   = SEQ_ST_EXEC,
    StMem    = SEQ_ST_MEM,
    StWb     = SEQ_ST_WB,
    StTrap   = SEQ_ST_TRAP
  } seq_state_e;

  typedef enum logic [1:0] {
    ClsR,
    ClsI,
    ClsS,
    ClsB
  } instr_cls_e;

  typedef struct packed {
    logic       legal;
    instr_cls_e cls;
  } dec_t;

  function automatic dec_t decode_instr(logic [6:0] opcode, logic [2:0] funct3);
    dec_t d;
    d.legal = 1'b1;
    d.cls   = ClsR;
    case (opcode)
      OPCODE_R: d.cls = ClsR;
      OPCODE_I: d.cls = ClsI;
      OPCODE_B: d.cls = ClsB;
      OPCODE_S: begin
        d.cls = ClsS;
        case (funct3)
          FUNCT_SB, FUNCT_SH, FUNCT_SW: d.legal = 1'b1;
          default:                      d.legal = 1'b0;
        endcase
      end
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/seq_ctrl_wait_timer.sv
// seq_wait_timer: wait-cycle counter shared by the FETCH and MEM states.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr_i      : reload the count with zero (state entry)
//   inc_i      : count one more cycle spent waiting for ready
//   expired_o  : the current waiting cycle is the MaxWait-th one
module seq_wait_timer #(
  parameter int unsigned MaxWait = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic inc_i,
  output logic expired_o
);

  localparam int unsigned CntW = $clog2(MaxWait + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != CntW'(MaxWait))) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // cnt_q holds the waits already seen, so this cycle completes the limit.
  assign expired_o = (cnt_q >= CntW'(MaxWait - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/seq_ctrl.sv
// seq_ctrl: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with memory handshakes.
//   Inputs : clk, rst_n (async active-low), run, opcode/funct3 (from IR), zero,
//            imem_ready, dmem_ready
//   Outputs: imem_req, ir_we, dmem_req, dmem_we, storeops, mem_to_reg, regwrite,
//            pc_we, pc_sel, trap, trap_cause, busy
// Optional build macro SEQ_PERF_CNT_EN adds instret / stall_cycles counters.
// Outputs are Moore decodes of the state, plus ready-qualified pulses (ir_we,
// store pc_we) and pc_sel following zero during a branch EXEC.
module seq_ctrl
  import seq_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       imem_req,
  output logic       ir_we,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic [1:0] storeops,
  output logic       mem_to_reg,
  output logic       regwrite,
  output logic       pc_we,
  output logic       pc_sel,
  output logic       trap,
  output logic [1:0] trap_cause,
  output logic       busy
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0] instret,
  output logic [31:0] stall_cycles
`endif
);

  seq_state_e state_q, state_d;
  instr_cls_e cls_q, cls_d;
  logic [1:0] cause_q, cause_d;
  logic       timer_clr, timer_inc, timer_expired;
  logic       tick_boundary;
  dec_t       dec;
  seq_state_e next_instr;

  seq_wait_timer #(
    .MaxWait (MEM_TIMEOUT)
  ) u_wait_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (timer_clr),
    .inc_i     (timer_inc),
    .expired_o (timer_expired)
  );

  assign dec        = decode_instr(opcode, funct3);
  // run is only honoured once the current instruction has retired.
  assign next_instr = run ? StFetch : StIdle;

  always_comb begin
    state_d       = state_q;
    cls_d         = cls_q;
    cause_d       = cause_q;
    timer_inc     = 1'b0;
    tick_boundary = 1'b0;
    imem_req      = 1'b0;
    ir_we         = 1'b0;
    dmem_req      = 1'b0;
    dmem_we       = 1'b0;
    storeops      = STORE_NONE;
    mem_to_reg    = 1'b0;
    regwrite      = 1'b0;
    pc_we         = 1'b0;
    pc_sel        = 1'b0;
    trap          = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (run) state_d = StFetch;
      end
      StFetch: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_we   = 1'b1;
          state_d = StDecode;
        end else begin
          timer_inc = 1'b1;
          if (timer_expired) begin
            state_d = StTrap;
            cause_d = TRAP_IMEM_TO;
          end
        end
      end
      StDecode: begin
        if (dec.legal) begin
          cls_d   = dec.cls;
          state_d = StExec;
        end else begin
          state_d = StTrap;
          cause_d = TRAP_ILLEGAL;
        end
      end
      StExec: begin
        unique case (cls_q)
          ClsR:       state_d = StWb;
          ClsI, ClsS: state_d = StMem;
          ClsB: begin
            pc_we         = 1'b1;
            pc_sel        = zero;
            tick_boundary = 1'b1;
          end
          default:    state_d = StTrap;
        endcase
      end
      StMem: begin
        dmem_req = 1'b1;
        if (cls_q == ClsS) begin
          dmem_we  = 1'b1;
          storeops = funct3[1:0] + 2'd1;
        end
        if (dmem_ready) begin
          if (cls_q == ClsS) begin
            pc_we         = 1'b1;
            tick_boundary = 1'b1;
          end else begin
            state_d = StWb;
          end
        end else begin
          timer_inc = 1'b1;
          if (timer_expired) begin
            state_d = StTrap;
            cause_d = TRAP_DMEM_TO;
          end
        end
      end
      StWb: begin
        regwrite      = 1'b1;
        mem_to_reg    = (cls_q == ClsI);
        pc_we         = 1'b1;
        tick_boundary = 1'b1;
      end
      StTrap: begin
        trap = 1'b1;
        if (!run) begin
          state_d = StIdle;
          cause_d = TRAP_NONE;
        end
      end
      default: state_d = StIdle;
    endcase

    if (tick_boundary) state_d = next_instr;
  end

  // Restart the wait count whenever FETCH or MEM is freshly entered.
  assign timer_clr  = ((state_d == StFetch) || (state_d == StMem)) && (state_d != state_q);
  assign trap_cause = cause_q;
  assign busy       = (state_q != StIdle);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cls_q   <= ClsR;
      cause_q <= TRAP_NONE;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      cause_q <= cause_d;
    end
  end

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] instret_q, instret_d, stall_q, stall_d;

  always_comb begin
    instret_d = instret_q + {31'd0, pc_we};
    stall_d   = stall_q + {31'd0, timer_inc};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret_q <= '0;
      stall_q   <= '0;
    end else begin
      instret_q <= instret_d;
      stall_q   <= stall_d;
    end
  end

  assign instret      = instret_q;
  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_seq_ctrl.sv
// tb_seq_ctrl: scoreboard bench for seq_ctrl. Each task pushes per-cycle
// stimulus with the expected output vector, then drains the queue, comparing
// the DUT outputs at the falling edge.
module tb_seq_ctrl;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_BAD = 7'b0010011;

  // Output vector bit map
  localparam logic [13:0] B_IMEM = 14'h2000;
  localparam logic [13:0] B_IRWE = 14'h1000;
  localparam logic [13:0] B_DREQ = 14'h0800;
  localparam logic [13:0] B_DWE  = 14'h0400;
  localparam logic [13:0] B_M2R  = 14'h0080;
  localparam logic [13:0] B_RW   = 14'h0040;
  localparam logic [13:0] B_PCWE = 14'h0020;
  localparam logic [13:0] B_PCS  = 14'h0010;
  localparam logic [13:0] B_TRAP = 14'h0008;
  localparam logic [13:0] B_C1   = 14'h0002;
  localparam logic [13:0] B_C2   = 14'h0004;
  localparam logic [13:0] B_C3   = 14'h0006;
  localparam logic [13:0] B_BUSY = 14'h0001;
  localparam logic [13:0] FETCHED = B_IMEM | B_IRWE | B_BUSY;

  logic clk = 1'b0;
  logic rst_n, run, zero, imem_ready, dmem_ready;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic imem_req, ir_we, dmem_req, dmem_we, mem_to_reg, regwrite, pc_we, pc_sel, trap, busy;
  logic [1:0] storeops, trap_cause;
  logic [13:0] outv;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0] instret, stall_cycles;
`endif

  typedef struct packed {
    logic        rn;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        z;
    logic        ir;
    logic        dr;
    logic [13:0] exp;
  } rec_t;

  rec_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   exp_instret = 0;
  int   exp_stall = 0;

  always #5 clk = ~clk;

  seq_ctrl #(
    .MEM_TIMEOUT (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run          (run),
    .opcode       (opcode),
    .funct3       (funct3),
    .zero         (zero),
    .imem_ready   (imem_ready),
    .dmem_ready   (dmem_ready),
    .imem_req     (imem_req),
    .ir_we        (ir_we),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .storeops     (storeops),
    .mem_to_reg   (mem_to_reg),
    .regwrite     (regwrite),
    .pc_we        (pc_we),
    .pc_sel       (pc_sel),
    .trap         (trap),
    .trap_cause   (trap_cause),
    .busy         (busy)
`ifdef SEQ_PERF_CNT_EN
    ,
    .instret      (instret),
    .stall_cycles (stall_cycles)
`endif
  );

  assign outv = {imem_req, ir_we, dmem_req, dmem_we, storeops, mem_to_reg, regwrite,
                 pc_we, pc_sel, trap, trap_cause, busy};

  // Build a cycle record; also tallies the expected performance counts.
  function automatic rec_t mk(input logic rn, input logic [6:0] op, input logic [2:0] f3,
                              input logic z, input logic ir, input logic dr,
                              input logic [13:0] exp);
    rec_t r;
    r = '{rn: rn, op: op, f3: f3, z: z, ir: ir, dr: dr, exp: exp};
    if ((exp & B_PCWE) != 14'h0) exp_instret++;
    if (((exp & B_IMEM) != 14'h0) && !ir) exp_stall++;
    if (((exp & B_DREQ) != 14'h0) && !dr) exp_stall++;
    return r;
  endfunction

  task automatic drive(input rec_t r);
    run = r.rn; opcode = r.op; funct3 = r.f3; zero = r.z;
    imem_ready = r.ir; dmem_ready = r.dr;
  endtask

  task automatic test_reset();
    run = 1'b1; opcode = OP_R; funct3 = 3'd0; zero = 1'b1;
    imem_ready = 1'b1; dmem_ready = 1'b1;
    #1;
    n_cmp++;
    if (outv !== 14'h0) begin
      n_err++; $display("FAIL reset_async: got %h want %h", outv, 14'h0);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (outv !== 14'h0) begin
      n_err++; $display("FAIL reset_held: got %h want %h", outv, 14'h0);
    end
    run = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (outv !== 14'h0) begin
      n_err++; $display("FAIL reset_idle: got %h want %h", outv, 14'h0);
    end
  endtask

  task automatic test_rtype();
    rec_t r;
    int   c = 0;
    sb.push_back(mk(1'b1, OP_R, 3'd0, 1'b0, 1'b1, 1'b0, 14'h0));
    sb.push_back(mk(1'b1, OP_R, 3'd0, 1'b0, 1'b1, 1'b0, FETCHED));
    sb.push_back(mk(1'b1, OP_R, 3'd0, 1'b0, 1'b1, 1'b0, B_BUSY));
    sb.push_back(mk(1'b1, OP_R, 3'd0, 1'b0, 1'b1, 1'b0, B_BUSY));
    sb.push_back(mk(1'b0, OP_R, 3'd0, 1'b0, 1'b1, 1'b0, B_RW | B_PCWE | B_BUSY));
    sb.push_back(mk(1'b0, OP_R, 3'd0, 1'b0, 1'b1, 1'b0, 14'h0));
    while (sb.size() != 0) begin
      r = sb.pop_front();
      drive(r);
      @(negedge clk);
      n_cmp++;
      if (outv !== r.exp) begin
        n_err++; $display("FAIL rtype cyc%0d: got %h want %h", c, outv, r.exp);
      end
      c++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load();
    rec_t r;
    int   c = 0;
    sb.push_back(mk(1'b1, OP_LD, 3'd2, 1'b0, 1'b0, 1'b0, 14'h0));
    sb.push_back(mk(1'b1, OP_LD, 3'd2, 1'b0, 1'b0, 1'b0, B_IMEM | B_BUSY));
    sb.push_back(mk(1'b1, OP_LD, 3'd2, 1'b0, 1'b0, 1'b0, B_IMEM | B_BUSY));
    sb.push_back(mk(1'b1, OP_LD, 3'd2, 1'b0, 1'b1, 1'b0, FETCHED));
    sb.push_back(mk(1'b1, OP_LD, 3'd2, 1'b0, 1'b0, 1'b0, B_BUSY));
    sb.push_back(mk(1'b1, OP_LD, 3'd2, 1'b0, 1'b0, 1'b0, B_BUSY));
    for (int i = 0; i < 3; i++)
      sb.push_back(mk(1'b1, OP_LD, 3'd2, 1'b0, 1'b0, 1'b0, B_DREQ | B_BUSY));
    sb.push_back(mk(1'b1, OP_LD, 3'd2, 1'b0, 1'b0, 1'b1, B_DREQ | B_BUSY));
    sb.push_back(mk(1'b0, OP_LD, 3'd2, 1'b0, 1'b0, 1'b0, B_M2R | B_RW | B_PCWE | B_BUSY));
    sb.push_back(mk(1'b0, OP_LD, 3'd2, 1'b0, 1'b0, 1'b0, 14'h0));
    while (sb.size() != 0) begin
      r = sb.pop_front();
      drive(r);
      @(negedge clk);
      n_cmp++;
      if (outv !== r.exp) begin
        n_err++; $display("FAIL load cyc%0d: got %h want %h", c, outv, r.exp);
      end
      c++;
      @(posedge clk); #1;
    end
  endtask

  // Three stores back to back (run held high), then two illegal encodings.
  task automatic test_store_back_to_back();
    rec_t        r;
    int          c = 0;
    logic [2:0]  f3;
    logic [13:0] sv;
    sb.push_back(mk(1'b1, OP_ST, 3'd0, 1'b0, 1'b1, 1'b0, 14'h0));
    for (int i = 0; i < 3; i++) begin
      f3 = 3'(i);
      sv = B_DREQ | B_DWE | B_BUSY | (14'(i + 1) << 8);
      sb.push_back(mk(1'b1, OP_ST, f3, 1'b0, 1'b1, 1'b0, FETCHED));
      sb.push_back(mk(1'b1, OP_ST, f3, 1'b0, 1'b1, 1'b0, B_BUSY));
      sb.push_back(mk(1'b1, OP_ST, f3, 1'b0, 1'b1, 1'b0, B_BUSY));
      sb.push_back(mk(1'b1, OP_ST, f3, 1'b0, 1'b1, 1'b0, sv));
      sb.push_back(mk(i < 2, OP_ST, f3, 1'b0, 1'b1, 1'b1, sv | B_PCWE));
    end
    sb.push_back(mk(1'b0, OP_ST, 3'd0, 1'b0, 1'b1, 1'b0, 14'h0));
    sb.push_back(mk(1'b1, OP_ST, 3'd3, 1'b0, 1'b1, 1'b0, 14'h0));
    sb.push_back(mk(1'b1, OP_ST, 3'd3, 1'b0, 1'b1, 1'b0, FETCHED));
    sb.push_back(mk(1'b1, OP_ST, 3'd3, 1'b0, 1'b1, 1'b0, B_BUSY));
    sb.push_back(mk(1'b1, OP_ST, 3'd3, 1'b0, 1'b1, 1'b0, B_TRAP | B_C1 | B_BUSY));
    sb.push_back(mk(1'b0, OP_ST, 3'd3, 1'b0, 1'b1, 1'b0, B_TRAP | B_C1 | B_BUSY));
    sb.push_back(mk(1'b1, OP_BAD, 3'd0, 1'b0, 1'b1, 1'b0, 14'h0));
    sb.push_back(mk(1'b1, OP_BAD, 3'd0, 1'b0, 1'b1, 1'b0, FETCHED));
    sb.push_back(mk(1'b1, OP_BAD, 3'd0, 1'b0, 1'b1, 1'b0, B_BUSY));
    sb.push_back(mk(1'b0, OP_BAD, 3'd0, 1'b0, 1'b1, 1'b0, B_TRAP | B_C1 | B_BUSY));
    sb.push_back(mk(1'b0, OP_BAD, 3'd0, 1'b0, 1'b1, 1'b0, 14'h0));
    while (sb.size() != 0) begin
      r = sb.pop_front();
      drive(r);
      @(negedge clk);
      n_cmp++;
      if (outv !== r.exp) begin
        n_err++; $display("FAIL store cyc%0d: got %h want %h", c, outv, r.exp);
      end
      c++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    rec_t r;
    int   c = 0;
    sb.push_back(mk(1'b1, OP_BR, 3'd0, 1'b1, 1'b1, 1'b0, 14'h0));
    sb.push_back(mk(1'b1, OP_BR, 3'd0, 1'b1, 1'b1, 1'b0, FETCHED));
    sb.push_back(mk(1'b1, OP_BR, 3'd0, 1'b1, 1'b1, 1'b0, B_BUSY));
    sb.push_back(mk(1'b1, OP_BR, 3'd0, 1'b1, 1'b1, 1'b0, B_PCWE | B_PCS | B_BUSY));
    sb.push_back(mk(1'b1, OP_BR, 3'd0, 1'b1, 1'b1, 1'b0, FETCHED));
    sb.push_back(mk(1'b1, OP_BR, 3'd0, 1'b1, 1'b1, 1'b0, B_BUSY));
    sb.push_back(mk(1'b0, OP_BR, 3'd0, 1'b0, 1'b1, 1'b0, B_PCWE | B_BUSY));
    sb.push_back(mk(1'b0, OP_BR, 3'd0, 1'b1, 1'b1, 1'b0, 14'h0));
    while (sb.size() != 0) begin
      r = sb.pop_front();
      drive(r);
      @(negedge clk);
      n_cmp++;
      if (outv !== r.exp) begin
        n_err++; $display("FAIL branch cyc%0d: got %h want %h", c, outv, r.exp);
      end
      c++;
      @(posedge clk); #1;
    end
  endtask

  // dmem timeout after 16 waits, ready on the 16th wait, and an imem timeout.
  task automatic test_timeout();
    rec_t r;
    int   c = 0;
    for (int k = 0; k < 2; k++) begin
      sb.push_back(mk(1'b1, OP_LD, 3'd2, 1'b0, 1'b1, 1'b0, 14'h0));
      sb.push_back(mk(1'b1, OP_LD, 3'd2, 1'b0, 1'b1, 1'b0, FETCHED));
      sb.push_back(mk(1'b1, OP_LD, 3'd2, 1'b0, 1'b1, 1'b0, B_BUSY));
      sb.push_back(mk(1'b1, OP_LD, 3'd2, 1'b0, 1'b1, 1'b0, B_BUSY));
      for (int i = 0; i < 15; i++)
        sb.push_back(mk(1'b1, OP_LD, 3'd2, 1'b0, 1'b1, 1'b0, B_DREQ | B_BUSY));
      if (k == 0) begin
        sb.push_back(mk(1'b1, OP_LD, 3'd2, 1'b0, 1'b1, 1'b0, B_DREQ | B_BUSY));
        sb.push_back(mk(1'b1, OP_LD, 3'd2, 1'b0, 1'b1, 1'b1, B_TRAP | B_C3 | B_BUSY));
        sb.push_back(mk(1'b0, OP_LD, 3'd2, 1'b0, 1'b1, 1'b1, B_TRAP | B_C3 | B_BUSY));
      end else begin
        sb.push_back(mk(1'b1, OP_LD, 3'd2, 1'b0, 1'b1, 1'b1, B_DREQ | B_BUSY));
        sb.push_back(mk(1'b0, OP_LD, 3'd2, 1'b0, 1'b1, 1'b0,
                        B_M2R | B_RW | B_PCWE | B_BUSY));
      end
      sb.push_back(mk(1'b0, OP_LD, 3'd2, 1'b0, 1'b1, 1'b0, 14'h0));
    end
    sb.push_back(mk(1'b1, OP_R, 3'd0, 1'b0, 1'b0, 1'b0, 14'h0));
    for (int i = 0; i < 16; i++)
      sb.push_back(mk(1'b1, OP_R, 3'd0, 1'b0, 1'b0, 1'b0, B_IMEM | B_BUSY));
    sb.push_back(mk(1'b0, OP_R, 3'd0, 1'b0, 1'b1, 1'b0, B_TRAP | B_C2 | B_BUSY));
    sb.push_back(mk(1'b0, OP_R, 3'd0, 1'b0, 1'b1, 1'b0, 14'h0));
    while (sb.size() != 0) begin
      r = sb.pop_front();
      drive(r);
      @(negedge clk);
      n_cmp++;
      if (outv !== r.exp) begin
        n_err++; $display("FAIL timeout cyc%0d: got %h want %h", c, outv, r.exp);
      end
      c++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_run_drop();
    rec_t r;
    int   c = 0;
    sb.push_back(mk(1'b1, OP_LD, 3'd2, 1'b0, 1'b1, 1'b0, 14'h0));
    sb.push_back(mk(1'b1, OP_LD, 3'd2, 1'b0, 1'b1, 1'b0, FETCHED));
    sb.push_back(mk(1'b0, OP_LD, 3'd2, 1'b0, 1'b1, 1'b0, B_BUSY));
    sb.push_back(mk(1'b0, OP_LD, 3'd2, 1'b0, 1'b1, 1'b0, B_BUSY));
    sb.push_back(mk(1'b0, OP_LD, 3'd2, 1'b0, 1'b1, 1'b1, B_DREQ | B_BUSY));
    sb.push_back(mk(1'b0, OP_LD, 3'd2, 1'b0, 1'b1, 1'b0, B_M2R | B_RW | B_PCWE | B_BUSY));
    sb.push_back(mk(1'b0, OP_LD, 3'd2, 1'b0, 1'b1, 1'b0, 14'h0));
    while (sb.size() != 0) begin
      r = sb.pop_front();
      drive(r);
      @(negedge clk);
      n_cmp++;
      if (outv !== r.exp) begin
        n_err++; $display("FAIL run_drop cyc%0d: got %h want %h", c, outv, r.exp);
      end
      c++;
      @(posedge clk); #1;
    end
`ifdef SEQ_PERF_CNT_EN
    n_cmp++;
    if (instret !== 32'(exp_instret)) begin
      n_err++; $display("FAIL instret: got %0d want %0d", instret, exp_instret);
    end
    n_cmp++;
    if (stall_cycles !== 32'(exp_stall)) begin
      n_err++; $display("FAIL stall_cycles: got %0d want %0d", stall_cycles, exp_stall);
    end
`endif
  endtask

  task automatic test_reset_abort();
    rec_t r;
    int   c = 0;
    sb.push_back(mk(1'b1, OP_LD, 3'd2, 1'b0, 1'b1, 1'b0, 14'h0));
    sb.push_back(mk(1'b1, OP_LD, 3'd2, 1'b0, 1'b1, 1'b0, FETCHED));
    sb.push_back(mk(1'b1, OP_LD, 3'd2, 1'b0, 1'b1, 1'b0, B_BUSY));
    sb.push_back(mk(1'b1, OP_LD, 3'd2, 1'b0, 1'b1, 1'b0, B_BUSY));
    sb.push_back(mk(1'b1, OP_LD, 3'd2, 1'b0, 1'b1, 1'b0, B_DREQ | B_BUSY));
    while (sb.size() != 0) begin
      r = sb.pop_front();
      drive(r);
      @(negedge clk);
      n_cmp++;
      if (outv !== r.exp) begin
        n_err++; $display("FAIL rst_abort cyc%0d: got %h want %h", c, outv, r.exp);
      end
      c++;
      if (sb.size() != 0) begin
        @(posedge clk); #1;
      end
    end
    // Mid-cycle in MEM: pull reset, outputs must drop without a clock edge.
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (outv !== 14'h0) begin
      n_err++; $display("FAIL rst_abort_async: got %h want %h", outv, 14'h0);
    end
    dmem_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (outv !== 14'h0) begin
      n_err++; $display("FAIL rst_abort_held: got %h want %h", outv, 14'h0);
    end
    run = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (outv !== 14'h0) begin
      n_err++; $display("FAIL rst_abort_idle: got %h want %h", outv, 14'h0);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (outv !== 14'h0) begin
      n_err++; $display("FAIL rst_abort_stays_idle: got %h want %h", outv, 14'h0);
    end
  endtask

  initial begin
    rst_n = 1'b1;
    run = 1'b0; opcode = '0; funct3 = '0; zero = 1'b0;
    imem_ready = 1'b0; dmem_ready = 1'b0;
    #1 rst_n = 1'b0;
    test_reset();
    test_rtype();
    test_load();
    test_store_back_to_back();
    test_branch();
    test_timeout();
    test_run_drop();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
